mfm_encoder: RTL and testbench
==============================

Name: mfm_encoder

Overview:
Upstream feeder for the MFM cell serializer/pulse generator on the 50 MHz domain.
- Accepts data bytes over a valid/ready handshake and encodes each into 16 MFM cells.
- Presents the cells one per downstream cell_req.
- Supports A1 sync marks with the missing clock (0x4489).
- Inserts gap-fill bytes on underrun so the cell stream never stalls.

Parameters:
FILL_BYTE, 8'h4E, byte encoded when no input byte is available at a word boundary
SYNC_CLEAR_CELL, 5, cell index (15 = first cell out) forced to 0 when byte_sync is set

Ports:
clk50  in  1  50 MHz clock
reset_l  in  1  asynchronous active-low reset
enable  in  1  run request; low returns the block to IDLE at the next word boundary
byte_data  in  8  data byte, MSB encoded first
byte_sync  in  1  qualifies byte_data as a sync mark (missing clock applied)
byte_valid  in  1  byte_data/byte_sync valid
byte_ready  out  1  byte accepted this cycle when byte_valid && byte_ready (combinational)
cell_req  in  1  one-cycle pulse from downstream: consume current cell
cell_bit  out  1  current MFM cell (1 = flux pulse)
cell_valid  out  1  cell_bit is meaningful
underrun  out  1  sticky: fill byte was inserted

Behaviour:
Reset values (async, reset_l low):
- cell_bit=0, cell_valid=0, underrun=0.
- State IDLE, shift reg=0, cell_cnt=0, prev_bit=0.

MFM rule (per data bit b, previous data bit p), producing clock cell then data cell:
- b=1 -> 01
- b=0, p=0 -> 10
- b=0, p=1 -> 00
- p is carried across bytes and fill bytes.
- Sync: normal encoding, then cell SYNC_CLEAR_CELL forced 0. A1 -> 0x4489.
- prev_bit after any byte = its bit0.

States:
- IDLE:
  - byte_ready = enable.
  - On accept: load encoded word, cell_cnt=0, go RUN.
  - Next cycle: cell_valid=1, cell_bit=word[15].
  - No fill is inserted in IDLE.
- RUN:
  - cell_valid=1, cell_bit=shift[15].
  - On cell_req: shift left, cell_cnt+1.
  - byte_ready = cell_req && cell_cnt==15 && enable. This is the only cycle a byte is taken in RUN.
  - Word boundary (cell_req && cell_cnt==15):
    - enable=1 and byte_valid -> load that byte's encoding; no gap cycle, next cell is new word[15].
    - enable=1 and !byte_valid -> load FILL_BYTE encoding (byte_sync=0), underrun<=1.
    - enable=0 -> go IDLE, cell_valid<=0, prev_bit kept.
- cell_req while cell_valid=0: ignored.
- cell_req held high: one cell consumed per cycle (legal; downstream normally pulses every 10 clocks).
- underrun clears only on reset or when in IDLE with enable=0.
- Changes of byte_data/byte_sync while not accepted: no effect.
- Reset mid-word: outputs drop immediately; partial word discarded; prev_bit=0.

Latency: byte accept -> first cell valid: 1 cycle.

Decomposition:
Package mfm_pkg:
- MFM_FILL_DEFAULT=8'h4E
- MFM_SYNC_A1=8'hA1
- MFM_SYNC_PATTERN=16'h4489
- MFM_CELLS_PER_BYTE=16
- State enum {IDLE, RUN}

Sub-module mfm_byte_encode (combinational):
- Inputs: byte, sync, prev_bit.
- Outputs: cells[15:0], last_bit.
- Instantiated once; its input is muxed between byte_data and FILL_BYTE.

Test Plan:
- Reset, enable=1, send 0x00 -> byte_ready high in IDLE; cells 0xAAAA via 16 cell_req; cell_valid rises 1 cycle after accept.
- Send 0xFF then 0x00 back-to-back -> cells 0x5555 then 0x2AAA; second byte_ready pulse coincides with the 16th cell_req; no cell_valid gap.
- Send 0x00 then sync 0xA1 -> 0xAAAA then 0x4489.
- After 0x00, hold byte_valid=0 at the boundary -> cells 0x9254 (0x4E fill); underrun=1 stays set; byte 0xFF then accepted at the next boundary.
- Drop enable mid-word -> current word finishes; cell_valid=0 after the 16th cell_req; underrun clears; byte_ready low until enable returns.
- Assert reset_l=0 at cell 7 -> cell_valid/cell_bit/underrun 0 same cycle; after release, 0x00 encodes 0xAAAA (prev_bit reset).

Source files
------------

// File: rtl/mfm_pkg.sv
// Shared definitions for the MFM encoder: default fill byte, the A1 sync mark
// and its missing-clock cell pattern, the word size in cells, and the FSM states.
package mfm_pkg;

  localparam logic [7:0]  MFM_FILL_DEFAULT   = 8'h4E;
  localparam logic [7:0]  MFM_SYNC_A1        = 8'hA1;
  localparam logic [15:0] MFM_SYNC_PATTERN   = 16'h4489;
  localparam int          MFM_CELLS_PER_BYTE = 16;

  typedef enum logic {
    IDLE,
    RUN
  } mfm_state_e;

endpackage

// File: rtl/mfm_byte_encode.sv
// Combinational MFM encoder for one byte.
//   byte_i     : data byte, MSB encoded first
//   sync_i     : apply the missing clock (clear cell SYNC_CLEAR_CELL)
//   prev_bit_i : last data bit of the previous byte
//   cells_o    : 16 cells, bit 15 is the first cell out
//   last_bit_o : data bit 0, carried into the next byte
module mfm_byte_encode
  import mfm_pkg::*;
#(
  parameter int SYNC_CLEAR_CELL = 5
) (
  input  logic        [7:0]                    byte_i,
  input  logic                                 sync_i,
  input  logic                                 prev_bit_i,
  output logic        [MFM_CELLS_PER_BYTE-1:0] cells_o,
  output logic                                 last_bit_o
);

  logic p;

  // Each data bit yields a clock cell (high only between two zeros) followed
  // by a data cell equal to the bit itself.
  always_comb begin
    // NOTE: blocking assignments here on purpose: p must carry each bit into
    // the next loop iteration within the same evaluation.
    cells_o = '0;
    p       = prev_bit_i;
    for (int i = 7; i >= 0; i--) begin
      cells_o[2*i+1] = ~byte_i[i] & ~p;
      cells_o[2*i]   = byte_i[i];
      p              = byte_i[i];
    end
    if (sync_i) begin
      cells_o[SYNC_CLEAR_CELL] = 1'b0;
    end
  end

  assign last_bit_o = byte_i[0];

endmodule

// File: rtl/mfm_encoder.sv
// MFM cell stream feeder. Bytes arrive on a valid/ready handshake, are encoded
// into 16 cells and shifted out one cell per cell_req. At a word boundary with
// no byte available a fill byte is encoded instead, so the stream never stalls.
//   clk50, reset_l          : clock, asynchronous active-low reset
//   enable                  : run request; low returns to IDLE at a word boundary
//   byte_data/sync/valid    : input byte, sync qualifier, valid
//   byte_ready              : combinational accept strobe
//   cell_req                : consume the current cell
//   cell_bit/cell_valid     : current cell and its qualifier
//   underrun                : sticky, a fill byte was inserted
module mfm_encoder
  import mfm_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE       = MFM_FILL_DEFAULT,
  parameter int         SYNC_CLEAR_CELL = 5
) (
  input  logic       clk50,
  input  logic       reset_l,
  input  logic       enable,
  input  logic [7:0] byte_data,
  input  logic       byte_sync,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       cell_req,
  output logic       cell_bit,
  output logic       cell_valid,
  output logic       underrun
);

  localparam logic [3:0] LAST_CELL = 4'(MFM_CELLS_PER_BYTE - 1);

  mfm_state_e                    state_q, state_d;
  logic [MFM_CELLS_PER_BYTE-1:0] shift_q, shift_d;
  logic [3:0]                    cnt_q, cnt_d;
  logic                          prev_q, prev_d;
  logic                          underrun_q, underrun_d;

  logic                          boundary;
  logic                          use_fill;
  logic [7:0]                    enc_byte;
  logic                          enc_sync;
  logic [MFM_CELLS_PER_BYTE-1:0] enc_cells;
  logic                          enc_last;

  // The last cell of the word is being consumed this cycle.
  assign boundary = (state_q == RUN) && cell_req && (cnt_q == LAST_CELL);
  assign use_fill = boundary && enable && !byte_valid;

  // One encoder, shared between the input byte and the gap-fill byte.
  assign enc_byte = use_fill ? FILL_BYTE : byte_data;
  assign enc_sync = !use_fill && byte_sync;

  mfm_byte_encode #(
    .SYNC_CLEAR_CELL(SYNC_CLEAR_CELL)
  ) u_encode (
    .byte_i    (enc_byte),
    .sync_i    (enc_sync),
    .prev_bit_i(prev_q),
    .cells_o   (enc_cells),
    .last_bit_o(enc_last)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    underrun_d = underrun_q;
    byte_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        byte_ready = enable;
        if (!enable) begin
          underrun_d = 1'b0;
        end else if (byte_valid) begin
          shift_d = enc_cells;
          cnt_d   = '0;
          prev_d  = enc_last;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cell_req) begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 4'd1;
          if (boundary) begin
            byte_ready = enable;
            if (enable) begin
              // Next word follows with no gap cycle; a fill byte if starved.
              shift_d = enc_cells;
              prev_d  = enc_last;
              if (use_fill) begin
                underrun_d = 1'b1;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      prev_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register
      // samples the values from before this edge.
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      underrun_q <= underrun_d;
    end
  end

  assign cell_valid = (state_q == RUN);
  assign cell_bit   = cell_valid && shift_q[MFM_CELLS_PER_BYTE-1];
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_mfm_encoder.sv
// Bench for mfm_encoder: expected cell words are queued when a byte (or a
// fill) is handed to the DUT and compared as the 16 cells are consumed.
module tb_mfm_encoder;
  import mfm_pkg::*;

  logic       clk50      = 1'b0;
  logic       reset_l    = 1'b0;
  logic       enable     = 1'b0;
  logic [7:0] byte_data  = 8'h00;
  logic       byte_sync  = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       cell_req   = 1'b0;
  logic       cell_bit;
  logic       cell_valid;
  logic       underrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        mdl_prev = 1'b0;
  logic [15:0] obs;

  mfm_encoder dut (
    .clk50     (clk50),
    .reset_l   (reset_l),
    .enable    (enable),
    .byte_data (byte_data),
    .byte_sync (byte_sync),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .cell_req  (cell_req),
    .cell_bit  (cell_bit),
    .cell_valid(cell_valid),
    .underrun  (underrun)
  );

  always #10 clk50 = ~clk50;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference MFM coding: per bit, 01 for a one, 10 for a zero after a zero,
  // 00 for a zero after a one; sync clears cell 5 (cell 15 goes out first).
  function automatic logic [15:0] mfm_model(input logic [7:0] b, input logic s, input logic p);
    logic [15:0] w;
    logic        prev;
    w    = 16'h0000;
    prev = p;
    for (int i = 7; i >= 0; i--) begin
      w = w << 2;
      if (b[i])      w[1:0] = 2'b01;
      else if (!prev) w[1:0] = 2'b10;
      else           w[1:0] = 2'b00;
      prev = b[i];
    end
    if (s) w[5] = 1'b0;
    return w;
  endfunction

  task automatic push_exp(input logic [7:0] b, input logic s);
    exp_q.push_back(mfm_model(b, s, mdl_prev));
    mdl_prev = b[0];
  endtask

  // Hand a byte to the DUT while it sits in IDLE.
  task automatic start_byte(input logic [7:0] b, input logic s);
    @(negedge clk50);
    enable     = 1'b1;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_sync  = s;
    #1;
    check("rdy_idle", byte_ready, 1'b1);
    check("cv_before_accept", cell_valid, 1'b0);
    push_exp(b, s);
    @(posedge clk50);
    #1;
    check("latency_1", cell_valid, 1'b1);
    @(negedge clk50);
    byte_valid = 1'b0;
  endtask

  // Consume one full word. At the 16th cell_req the next byte (nv=1) or no
  // byte (nv=0) is offered; enable is set to en_end from cell 8 onward.
  // gap = idle cycles between requests (0 keeps cell_req held high).
  task automatic run_word(input logic nv, input logic [7:0] nb, input logic ns,
                          input logic en_end, input int gap, output logic [15:0] w);
    w = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk50);
      if (c == 8) enable = en_end;
      cell_req = 1'b1;
      if (c == 15) begin
        byte_valid = nv;
        byte_data  = nb;
        byte_sync  = ns;
      end
      #1;
      check("cell_valid_run", cell_valid, 1'b1);
      w = {w[14:0], cell_bit};
      if (c == 15) begin
        check("rdy_boundary", byte_ready, en_end);
        if (en_end) begin
          if (nv) push_exp(nb, ns);
          else    push_exp(MFM_FILL_DEFAULT, 1'b0);
        end
      end else begin
        check("rdy_mid_word", byte_ready, 1'b0);
      end
      if (gap > 0) begin
        @(negedge clk50);
        cell_req   = 1'b0;
        byte_valid = 1'b0;
        repeat (gap - 1) @(negedge clk50);
      end
    end
    if (gap == 0) begin
      @(negedge clk50);
      cell_req   = 1'b0;
      byte_valid = 1'b0;
    end
    check("sb_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) check("word", w, exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    @(negedge clk50);
    check("rst_cell_valid", cell_valid, 1'b0);
    check("rst_cell_bit", cell_bit, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready_disabled", byte_ready, 1'b0);
    @(negedge clk50);
    reset_l = 1'b1;
    @(negedge clk50);
    enable = 1'b1;
    #1;
    check("rdy_idle_no_valid", byte_ready, 1'b1);

    // Basic words, back-to-back bytes, sync mark
    start_byte(8'h00, 1'b0);
    run_word(1'b1, 8'hFF, 1'b0, 1'b1, 2, obs);
    check("w_00", obs, 16'hAAAA);
    run_word(1'b1, 8'h00, 1'b0, 1'b1, 0, obs);
    check("w_ff", obs, 16'h5555);
    run_word(1'b1, MFM_SYNC_A1, 1'b1, 1'b1, 1, obs);
    check("w_00_after_ff", obs, 16'h2AAA);
    run_word(1'b1, 8'h00, 1'b0, 1'b1, 3, obs);
    check("w_sync_a1", obs, MFM_SYNC_PATTERN);
    check("underrun_clear", underrun, 1'b0);

    // Underrun: no byte at the boundary -> fill byte, sticky flag
    run_word(1'b0, 8'hFF, 1'b0, 1'b1, 2, obs);
    check("w_00_after_a1", obs, 16'h2AAA);
    check("underrun_set", underrun, 1'b1);
    run_word(1'b1, 8'hFF, 1'b0, 1'b1, 2, obs);
    check("w_fill", obs, 16'h9254);
    check("underrun_sticky", underrun, 1'b1);

    // Random bytes through the scoreboard
    for (int k = 0; k < 4; k++) begin
      logic [7:0] rb;
      logic       rs;
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_word(1'b1, rb, rs, 1'b1, int'($urandom_range(0, 3)), obs);
    end
    check("underrun_still_set", underrun, 1'b1);

    // Drop enable mid-word: word finishes, then IDLE, underrun clears
    run_word(1'b1, 8'h5A, 1'b0, 1'b0, 2, obs);
    check("cv_after_disable", cell_valid, 1'b0);
    check("underrun_cleared", underrun, 1'b0);
    @(negedge clk50);
    byte_valid = 1'b1;
    cell_req   = 1'b1;
    #1;
    check("rdy_disabled", byte_ready, 1'b0);
    @(negedge clk50);
    byte_valid = 1'b0;
    cell_req   = 1'b0;
    #1;
    check("cv_req_ignored", cell_valid, 1'b0);

    // Reset mid-word: outputs drop at once, prev_bit returns to 0
    start_byte(8'h01, 1'b0);
    run_word(1'b0, 8'h00, 1'b0, 1'b1, 1, obs);
    check("underrun_before_rst", underrun, 1'b1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk50);
      cell_req = 1'b1;
      @(negedge clk50);
      cell_req = 1'b0;
    end
    #1;
    check("cv_before_rst", cell_valid, 1'b1);
    reset_l = 1'b0;
    #1;
    check("rst_mid_cell_valid", cell_valid, 1'b0);
    check("rst_mid_cell_bit", cell_bit, 1'b0);
    check("rst_mid_underrun", underrun, 1'b0);
    exp_q.delete();
    mdl_prev = 1'b0;
    @(negedge clk50);
    reset_l = 1'b1;
    start_byte(8'h00, 1'b0);
    run_word(1'b0, 8'h00, 1'b0, 1'b0, 1, obs);
    check("w_00_after_rst", obs, 16'hAAAA);
    check("cv_final_idle", cell_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
